// File: rtl/burst_sram_slave_pkg.sv
// Shared definitions for the burst-bus SRAM slave: FSM state encoding, the bus-idle
// value and the beat-count helpers. Masters and this slave agree that beats = burstSize + 1.
package burst_sram_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdSetup,
    StRdBurst,
    StRdEnd,
    StWrBurst,
    StErrEnd
  } state_t;

  // Value driven on the wired-OR bus by an inactive slave.
  localparam logic [31:0] BusIdle = 32'd0;

  // Number of beats encoded by an 8-bit burst size field (1..256).
  function automatic logic [8:0] beats_from_size(input logic [7:0] size);
    return {1'b0, size} + 9'd1;
  endfunction

  // True when the last beat of a burst starting at word_addr falls outside the window.
  function automatic logic last_beat_overflows(input logic [31:0] word_addr,
                                               input logic [7:0]  size,
                                               input int unsigned addr_width);
    logic [31:0] last_word;
    last_word = word_addr + {24'd0, size};
    return last_word > ((32'd1 << addr_width) - 32'd1);
  endfunction

endpackage

// File: rtl/burst_sram_mem.sv
// Single-port synchronous word RAM, 2^ADDR_WIDTH x 32, with per-byte write enables.
// Ports:
//   clk_i    clock
//   re_i     read strobe; rdata_o updates on the next edge (1-cycle latency)
//   we_i     write strobe, masked per byte by be_i (be_i[0] = bits 7:0)
//   addr_i   word address shared by read and write
//   wdata_i  write data
//   rdata_o  registered read data; holds its value between reads
module burst_sram_mem #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_sram_slave.sv
// Word SRAM acting as a slave on the shared burst bus. Serves single and burst
// reads/writes, flags bursts that run off the end of its window, and can insert
// periodic busy cycles on the write path to exercise master stall handling.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   beginTransactionIn      start strobe; addressDataIn carries the byte address
//   addressDataIn           address at begin, write data on dataValidIn
//   readNotWriteIn          1 = read, 0 = write (sampled at begin)
//   burstSizeIn             beats - 1 (sampled at begin)
//   byteEnablesIn           byte mask for every write beat (sampled at begin)
//   dataValidIn             write beat valid
//   endTransactionIn        master ends the write burst
//   addressDataOut          read data, 0 when dataValidOut is low
//   dataValidOut            read beat valid
//   endTransactionOut       1-cycle end of read burst or error
//   busyOut                 write beat not accepted this cycle
//   busErrorOut             1-cycle address error, with endTransactionOut
module burst_sram_slave
  import burst_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BUSY_EVERY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic        readNotWriteIn,
  input  logic [7:0]  burstSizeIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busyOut,
  output logic        busErrorOut
);

  localparam int unsigned TagLsb = ADDR_WIDTH + 2;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [8:0]            beats_q, beats_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           busy_cnt_q, busy_cnt_d;
  logic                  data_valid_q, data_valid_d;
  logic                  end_q, end_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  ram_re, ram_we;
  logic [31:0]           ram_rdata;

  logic                  hit;
  logic [ADDR_WIDTH-1:0] begin_word;
  logic                  begin_overflow;
  logic                  wr_accept;

  // Byte offset within a word plays no part in decode.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addressDataIn[1:0];

  assign hit            = addressDataIn[31:TagLsb] == BASE_ADDR[31:TagLsb];
  assign begin_word     = addressDataIn[TagLsb-1:2];
  assign begin_overflow = last_beat_overflows(32'(begin_word), burstSizeIn, ADDR_WIDTH);
  assign wr_accept      = dataValidIn && !busy_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    beats_d      = beats_q;
    be_d         = be_q;
    busy_cnt_d   = busy_cnt_q;
    data_valid_d = 1'b0;
    end_d        = 1'b0;
    err_d        = 1'b0;
    busy_d       = 1'b0;
    ram_re       = 1'b0;
    ram_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (beginTransactionIn && hit) begin
          addr_d     = begin_word;
          beats_d    = beats_from_size(burstSizeIn);
          be_d       = byteEnablesIn;
          cnt_d      = '0;
          busy_cnt_d = '0;
          if (begin_overflow) begin
            state_d = StErrEnd;
          end else if (readNotWriteIn) begin
            state_d = StRdSetup;
          end else begin
            state_d = StWrBurst;
          end
        end
      end

      StRdSetup: begin
        ram_re       = 1'b1;
        addr_d       = addr_q + 1'b1;
        cnt_d        = 9'd1;
        data_valid_d = 1'b1;
        state_d      = StRdBurst;
      end

      // cnt_q counts reads issued; the word for the beat shown now was fetched last cycle.
      StRdBurst: begin
        if (cnt_q < beats_q) begin
          ram_re       = 1'b1;
          addr_d       = addr_q + 1'b1;
          cnt_d        = cnt_q + 9'd1;
          data_valid_d = 1'b1;
        end else begin
          end_d   = 1'b1;
          state_d = StRdEnd;
        end
      end

      StRdEnd: begin
        state_d = StIdle;
      end

      StWrBurst: begin
        if (wr_accept) begin
          // Beats past the burst length are accepted but dropped.
          if (cnt_q < beats_q) begin
            ram_we = 1'b1;
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 9'd1;
          end
          if (BUSY_EVERY != 0) begin
            if (busy_cnt_q + 32'd1 == BUSY_EVERY) begin
              busy_d     = 1'b1;
              busy_cnt_d = '0;
            end else begin
              busy_cnt_d = busy_cnt_q + 32'd1;
            end
          end
        end
        if (endTransactionIn) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

      StErrEnd: begin
        err_d   = 1'b1;
        end_d   = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      cnt_q        <= '0;
      beats_q      <= '0;
      be_q         <= '0;
      busy_cnt_q   <= '0;
      data_valid_q <= 1'b0;
      end_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      beats_q      <= beats_d;
      be_q         <= be_d;
      busy_cnt_q   <= busy_cnt_d;
      data_valid_q <= data_valid_d;
      end_q        <= end_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  // A beat arriving in the reset cycle must not reach the array.
  burst_sram_mem #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i  (clock),
    .re_i   (ram_re && !reset),
    .we_i   (ram_we && !reset),
    .be_i   (be_q),
    .addr_i (addr_q),
    .wdata_i(addressDataIn),
    .rdata_o(ram_rdata)
  );

  assign addressDataOut    = data_valid_q ? ram_rdata : BusIdle;
  assign dataValidOut      = data_valid_q;
  assign endTransactionOut = end_q;
  assign busyOut           = busy_q;
  assign busErrorOut       = err_q;

endmodule

// File: tb/tb_burst_sram_slave.sv
module tb_burst_sram_slave;

  localparam logic [31:0] Base = 32'h5000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        beginTransactionIn = 1'b0;
  logic [31:0] addressDataIn = '0;
  logic        readNotWriteIn = 1'b0;
  logic [7:0]  burstSizeIn = '0;
  logic [3:0]  byteEnablesIn = '0;
  logic        dataValidIn = 1'b0;
  logic        endTransactionIn = 1'b0;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busyOut;
  logic        busErrorOut;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  burst_sram_slave #(
    .BASE_ADDR (Base),
    .ADDR_WIDTH(10),
    .BUSY_EVERY(2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .beginTransactionIn(beginTransactionIn),
    .addressDataIn    (addressDataIn),
    .readNotWriteIn   (readNotWriteIn),
    .burstSizeIn      (burstSizeIn),
    .byteEnablesIn    (byteEnablesIn),
    .dataValidIn      (dataValidIn),
    .endTransactionIn (endTransactionIn),
    .addressDataOut   (addressDataOut),
    .dataValidOut     (dataValidOut),
    .endTransactionOut(endTransactionOut),
    .busyOut          (busyOut),
    .busErrorOut      (busErrorOut)
  );

  // {dataValid, end, busy, error, data}
  function automatic logic [35:0] obs();
    return {dataValidOut, endTransactionOut, busyOut, busErrorOut, addressDataOut};
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Drives a begin in the current cycle; returns one cycle later (cycle 1).
  task automatic start_txn(input logic [31:0] addr, input logic rnw, input logic [7:0] size,
                           input logic [3:0] be);
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    readNotWriteIn     = rnw;
    burstSizeIn        = size;
    byteEnablesIn      = be;
    next_cycle();
    beginTransactionIn = 1'b0;
    addressDataIn      = '0;
  endtask

  // Master-side write: re-presents a beat while busy, then ends the burst.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] size, input logic [3:0] be,
                          input logic [31:0] data [8], input int n);
    int i = 0;
    int guard = 0;
    start_txn(addr, 1'b0, size, be);
    while (i < n && guard < 64) begin
      dataValidIn   = 1'b1;
      addressDataIn = data[i];
      @(negedge clock);
      if (!busyOut) i++;
      next_cycle();
      guard++;
    end
    dataValidIn   = 1'b0;
    addressDataIn = '0;
    n_cmp++;
    if (i != n) begin
      n_err++;
      $display("FAIL write_progress got %0d beats want %0d", i, n);
    end
    endTransactionIn = 1'b1;
    next_cycle();
    endTransactionIn = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (obs() !== 36'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want %h", obs(), 36'd0);
    end
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_read();
    logic [31:0] d [8];
    logic [35:0] exp;
    d[0] = 32'hCAFE_0004;
    do_write(Base + 32'h10, 8'd0, 4'hF, d, 1);
    start_txn(Base + 32'h10, 1'b1, 8'd0, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      exp = '0;
      if (k == 2) exp = {4'b1000, 32'hCAFE_0004};
      if (k == 3) exp = {4'b0100, 32'h0};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL single_read cyc%0d got %h want %h", k, obs(), exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_burst_write_read();
    logic [31:0] d [8];
    logic [35:0] exp;
    for (int i = 0; i < 8; i++) d[i] = 32'hA0 + 32'(i);
    do_write(Base + 32'h40, 8'd7, 4'hF, d, 8);
    start_txn(Base + 32'h40, 1'b1, 8'd7, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      exp = '0;
      if (k >= 2 && k <= 9) exp = {4'b1000, 32'hA0 + 32'(k - 2)};
      if (k == 10) exp = {4'b0100, 32'h0};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL burst_read cyc%0d got %h want %h", k, obs(), exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d [8];
    logic [35:0] exp;
    d[0] = 32'h1234_5678;
    d[1] = 32'h9ABC_DEF0;
    do_write(Base + 32'h80, 8'd1, 4'hF, d, 2);
    // Size 0 with two beats: the second must be dropped, leaving word 0x21 intact.
    d[0] = 32'hFFFF_FFFF;
    d[1] = 32'hFFFF_FFFF;
    do_write(Base + 32'h80, 8'd0, 4'b0011, d, 2);
    start_txn(Base + 32'h80, 1'b1, 8'd1, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      exp = '0;
      if (k == 2) exp = {4'b1000, 32'h1234_FFFF};
      if (k == 3) exp = {4'b1000, 32'h9ABC_DEF0};
      if (k == 4) exp = {4'b0100, 32'h0};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL byte_enable cyc%0d got %h want %h", k, obs(), exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_busy();
    logic [35:0] exp;
    logic        exp_busy;
    logic        prev_acc = 1'b0;
    int          acc = 0;
    int          guard = 0;
    int          busy_obs = 0;
    start_txn(Base + 32'h100, 1'b0, 8'd5, 4'hF);
    while (acc < 6 && guard < 32) begin
      dataValidIn   = 1'b1;
      addressDataIn = 32'hB0 + 32'(acc);
      @(negedge clock);
      exp_busy = prev_acc && (acc % 2 == 0);
      n_cmp++;
      if (busyOut !== exp_busy) begin
        n_err++;
        $display("FAIL busy_beat%0d got %b want %b", acc, busyOut, exp_busy);
      end
      if (busyOut) busy_obs++;
      prev_acc = !exp_busy;
      if (!exp_busy) acc++;
      next_cycle();
      guard++;
    end
    dataValidIn   = 1'b0;
    addressDataIn = '0;
    n_cmp++;
    if (busy_obs != 2) begin
      n_err++;
      $display("FAIL busy_count got %0d want %0d", busy_obs, 2);
    end
    endTransactionIn = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (busyOut !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_beat6 got %b want %b", busyOut, 1'b1);
    end
    next_cycle();
    endTransactionIn = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (busyOut !== 1'b0) begin
      n_err++;
      $display("FAIL busy_idle got %b want %b", busyOut, 1'b0);
    end
    next_cycle();
    start_txn(Base + 32'h100, 1'b1, 8'd5, 4'hF);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      exp = '0;
      if (k >= 2 && k <= 7) exp = {4'b1000, 32'hB0 + 32'(k - 2)};
      if (k == 8) exp = {4'b0100, 32'h0};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL busy_readback cyc%0d got %h want %h", k, obs(), exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_error();
    logic [31:0] d [8];
    logic [35:0] exp;
    d[0] = 32'hE000_03FE;
    d[1] = 32'hE000_03FF;
    do_write(Base + 32'hFF8, 8'd1, 4'hF, d, 2);
    // Word 1022 + 3 runs past word 1023.
    start_txn(Base + 32'hFF8, 1'b0, 8'd3, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      dataValidIn   = 1'b1;
      addressDataIn = 32'h0BAD_0000 + 32'(k);
      @(negedge clock);
      exp = '0;
      if (k == 2) exp = {4'b0101, 32'h0};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL error_resp cyc%0d got %h want %h", k, obs(), exp);
      end
      next_cycle();
    end
    dataValidIn   = 1'b0;
    addressDataIn = '0;
    start_txn(Base + 32'hFF8, 1'b1, 8'd1, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      exp = '0;
      if (k == 2) exp = {4'b1000, 32'hE000_03FE};
      if (k == 3) exp = {4'b1000, 32'hE000_03FF};
      if (k == 4) exp = {4'b0100, 32'h0};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL error_mem cyc%0d got %h want %h", k, obs(), exp);
      end
      next_cycle();
    end
    // Just above the window: another slave's address.
    start_txn(Base + 32'h1000, 1'b1, 8'd0, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      n_cmp++;
      if (obs() !== 36'd0) begin
        n_err++;
        $display("FAIL nohit cyc%0d got %h want %h", k, obs(), 36'd0);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [35:0] exp;
    start_txn(Base + 32'h40, 1'b1, 8'd7, 4'hF);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) reset = 1'b1;
      @(negedge clock);
      exp = '0;
      if (k >= 2) exp = {4'b1000, 32'hA0 + 32'(k - 2)};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL pre_reset cyc%0d got %h want %h", k, obs(), exp);
      end
      next_cycle();
    end
    reset = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      @(negedge clock);
      n_cmp++;
      if (obs() !== 36'd0) begin
        n_err++;
        $display("FAIL post_reset cyc%0d got %h want %h", k, obs(), 36'd0);
      end
      next_cycle();
    end
    start_txn(Base + 32'h44, 1'b1, 8'd1, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      exp = '0;
      if (k == 2) exp = {4'b1000, 32'hA1};
      if (k == 3) exp = {4'b1000, 32'hA2};
      if (k == 4) exp = {4'b0100, 32'h0};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL after_reset_read cyc%0d got %h want %h", k, obs(), exp);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write_read();
    test_byte_enable();
    test_busy();
    test_error();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
